hscan_timing: RTL and testbench

Horizontal scan timing generator for the 640x480 VGA scanner. Sits directly upstream of the vertical line counter: divides the board clock down to the pixel rate, counts pixels across each line, and produces horizontal blanking, horizontal sync, a visible-pixel X coordinate and the line clock that advances the vertical counter once per line. All outputs are registered and glitch-free so the line clock may drive a downstream clock input directly.

---
 rtl/hscan_timing.sv | 111 +++++++++++
 tb/tb_hscan_timing.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/hscan_timing.sv
// hscan_timing - horizontal scan timing generator (640x480 VGA).
//
// Divides the board clock to the pixel rate, counts pixels across a line and
// produces blanking, sync, visible X coordinate, an end-of-line strobe and a
// line clock for the vertical counter. Every output is a flop.
//
// Optional feature macro: HSCAN_DIV2_EN
//   defined   : pen is high on alternate clkh cycles (divide-by-2)
//   undefined : pen is high every cycle after reset (no divider)
//
// Ports:
//   clkh   in   board clock, rising edge
//   clrh   in   synchronous active-high reset
//   cntrh  out  [9:0] pixel count 0..H_TOTAL-1
//   pen    out  pixel enable (high on cycles where the count just stepped)
//   hr     out  horizontal blank (0 only in the visible region)
//   hrs    out  horizontal sync, active-high
//   xpos   out  [9:0] visible X coordinate, 0 outside visible region
//   lend   out  one-cycle strobe when cntrh wraps to 0
//   lclk   out  line clock, rises on the wrap to 0
module hscan_timing #(
    parameter int H_BP    = 48,
    parameter int H_ACT   = 640,
    parameter int H_FP    = 16,
    parameter int H_TOTAL = 800
) (
    input  logic       clkh,
    input  logic       clrh,
    output logic [9:0] cntrh,
    output logic       pen,
    output logic       hr,
    output logic       hrs,
    output logic [9:0] xpos,
    output logic       lend,
    output logic       lclk
);

    localparam logic [9:0] VIS_LO  = 10'(H_BP);
    localparam logic [9:0] VIS_HI  = 10'(H_BP + H_ACT);        // first front-porch count
    localparam logic [9:0] SYNC_LO = 10'(H_BP + H_ACT + H_FP);  // first sync count
    localparam logic [9:0] LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] HALF    = 10'(H_TOTAL / 2);

    logic [9:0] cnt_q, cnt_d;
    logic [9:0] xpos_q, xpos_d;
    logic       pen_q, pen_d;
    logic       hr_q, hr_d;
    logic       hrs_q, hrs_d;
    logic       lend_q, lend_d;
    logic       lclk_q, lclk_d;
    logic       wrap;
`ifdef HSCAN_DIV2_EN
    logic       phase_q, phase_d;
`endif

    always_comb begin
`ifdef HSCAN_DIV2_EN
        // pen lags the phase bit by one cycle, so the first pen after reset
        // lands on the second edge.
        phase_d = ~phase_q;
        pen_d   = phase_q;
`else
        pen_d   = 1'b1;
`endif
        wrap   = (cnt_q == LAST);
        cnt_d  = cnt_q;
        if (pen_d) cnt_d = wrap ? 10'd0 : cnt_q + 10'd1;
        lend_d = pen_d && wrap;

        // Decode from the next count so outputs line up with cntrh.
        hr_d   = !((cnt_d >= VIS_LO) && (cnt_d < VIS_HI));
        hrs_d  = (cnt_d >= SYNC_LO);
        xpos_d = hr_d ? 10'd0 : cnt_d - VIS_LO;
        lclk_d = (cnt_d < HALF);
    end

    always_ff @(posedge clkh) begin
        if (clrh) begin
`ifdef HSCAN_DIV2_EN
            phase_q <= 1'b0;
`endif
            cnt_q  <= 10'd0;
            pen_q  <= 1'b0;
            hr_q   <= 1'b1;
            hrs_q  <= 1'b0;
            xpos_q <= 10'd0;
            lend_q <= 1'b0;
            lclk_q <= 1'b1;   // matches count 0, so reset never makes a rising edge
        end else begin
`ifdef HSCAN_DIV2_EN
            phase_q <= phase_d;
`endif
            cnt_q  <= cnt_d;
            pen_q  <= pen_d;
            hr_q   <= hr_d;
            hrs_q  <= hrs_d;
            xpos_q <= xpos_d;
            lend_q <= lend_d;
            lclk_q <= lclk_d;
        end
    end

    assign cntrh = cnt_q;
    assign pen   = pen_q;
    assign hr    = hr_q;
    assign hrs   = hrs_q;
    assign xpos  = xpos_q;
    assign lend  = lend_q;
    assign lclk  = lclk_q;

endmodule

// File: tb/tb_hscan_timing.sv
// Testbench for hscan_timing: reference model derived from the number of
// clkh edges since reset release, a table of region-boundary vectors,
// hand-written reset / full-line / multi-line sequences and random resets.
module tb_hscan_timing;

`ifdef HSCAN_DIV2_EN
    localparam int DIV = 2;
`else
    localparam int DIV = 1;
`endif
    localparam int NLINES = 25;

    logic       clkh = 1'b0;
    logic       clrh = 1'b1;
    logic [9:0] cntrh, xpos;
    logic       pen, hr, hrs, lend, lclk;

    hscan_timing dut (
        .clkh(clkh), .clrh(clrh), .cntrh(cntrh), .pen(pen), .hr(hr),
        .hrs(hrs), .xpos(xpos), .lend(lend), .lclk(lclk)
    );

    always #5 clkh = ~clkh;

    int vectors = 0;
    int miscompares = 0;
    int k = 0;          // edges since reset release (0 = in reset)
    int rises = 0, lends = 0, pens = 0, hrs_cyc = 0, maxcnt = 0;
    int edges = 0, last_lend_edge = -1, bad_period = 0;
    logic prev_lclk = 1'b1;

    typedef struct packed {
        logic [9:0] c;
        logic       p, hr, hrs;
        logic [9:0] x;
        logic       lend, lclk;
    } out_t;

    typedef struct {
        int   c;
        logic hr, hrs;
        int   x;
        logic lclk;
    } vec_t;

    // Expected outputs computed straight from the line rules.
    function automatic out_t model(int kk);
        out_t o;
        int steps, c;
        logic p;
        if (kk == 0) begin steps = 0; p = 1'b0; end
        else if (DIV == 2) begin steps = kk / 2; p = (kk % 2 == 0); end
        else begin steps = kk; p = 1'b1; end
        c = steps % 800;
        o.c    = 10'(c);
        o.p    = p;
        o.hr   = !(c >= 48 && c < 688);
        o.hrs  = (c >= 704);
        o.x    = o.hr ? 10'd0 : 10'(c - 48);
        o.lend = p && steps > 0 && c == 0;
        o.lclk = (c < 400);
        return o;
    endfunction

    task automatic chk(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clkh edge with the given reset level; checks every output.
    task automatic step(logic rst);
        out_t act, exp;
        @(negedge clkh);
        clrh = rst;
        @(posedge clkh);
        #1;
        edges++;
        k = rst ? 0 : k + 1;
        act = {cntrh, pen, hr, hrs, xpos, lend, lclk};
        exp = model(k);
        chk($sformatf("outputs@edge%0d", edges), int'(act), int'(exp));
        if (lclk && !prev_lclk) rises++;
        prev_lclk = lclk;
        if (pen) pens++;
        if (hrs) hrs_cyc++;
        if (int'(cntrh) > maxcnt) maxcnt = int'(cntrh);
        if (lend) begin
            if (last_lend_edge >= 0 && edges - last_lend_edge != 800 * DIV) bad_period++;
            last_lend_edge = edges;
            lends++;
        end
    endtask

    task automatic advance_to(int target);
        int n;
        n = 0;
        while (int'(model(k).c) != target && n < 2000) begin
            step(1'b0);
            n++;
        end
        if (n >= 2000) chk($sformatf("reach_count_%0d", target), n, 0);
    endtask

    vec_t tbl[10];

    initial begin
        tbl[0] = '{47,  1'b1, 1'b0, 0,   1'b1};
        tbl[1] = '{48,  1'b0, 1'b0, 0,   1'b1};
        tbl[2] = '{399, 1'b0, 1'b0, 351, 1'b1};
        tbl[3] = '{400, 1'b0, 1'b0, 352, 1'b0};
        tbl[4] = '{687, 1'b0, 1'b0, 639, 1'b0};
        tbl[5] = '{688, 1'b1, 1'b0, 0,   1'b0};
        tbl[6] = '{703, 1'b1, 1'b0, 0,   1'b0};
        tbl[7] = '{704, 1'b1, 1'b1, 0,   1'b0};
        tbl[8] = '{799, 1'b1, 1'b1, 0,   1'b0};
        tbl[9] = '{0,   1'b1, 1'b0, 0,   1'b1};

        // Reset state
        step(1'b1);
        step(1'b1);
        chk("reset_cntrh", int'(cntrh), 0);
        chk("reset_pen", int'(pen), 0);
        chk("reset_lclk", int'(lclk), 1);
        chk("reset_hr", int'(hr), 1);

        // Reset mid-line at count 300, held 3 cycles
        advance_to(300);
        begin
            int r0;
            r0 = rises;
            repeat (3) step(1'b1);
            chk("midreset_cntrh", int'(cntrh), 0);
            chk("midreset_lclk", int'(lclk), 1);
            chk("midreset_lend", int'(lend), 0);
            chk("midreset_no_rise", rises - r0, 0);
        end

        // One full line from reset release
        rises = 0; lends = 0; pens = 0; hrs_cyc = 0; last_lend_edge = -1;
        repeat (800 * DIV) step(1'b0);
        chk("line_cntrh_end", int'(cntrh), 0);
        chk("line_lend_pulses", lends, 1);
        chk("line_lclk_rises", rises, 1);
        chk("line_pen_count", pens, 800);
        chk("line_hrs_cycles", hrs_cyc, 96 * DIV);
        chk("line_lend_with_rise", int'(lend && lclk), 1);

        // Region boundaries
        for (int i = 0; i < 10; i++) begin
            advance_to(tbl[i].c);
            chk($sformatf("tbl%0d_hr", i), int'(hr), int'(tbl[i].hr));
            chk($sformatf("tbl%0d_hrs", i), int'(hrs), int'(tbl[i].hrs));
            chk($sformatf("tbl%0d_xpos", i), int'(xpos), tbl[i].x);
            chk($sformatf("tbl%0d_lclk", i), int'(lclk), int'(tbl[i].lclk));
        end

        // Multi-line: starts right after a wrap
        rises = 0; lends = 0; hrs_cyc = 0; maxcnt = 0; bad_period = 0;
        repeat (NLINES * 800 * DIV) step(1'b0);
        chk("multi_lend_pulses", lends, NLINES);
        chk("multi_lclk_rises", rises, NLINES);
        chk("multi_hrs_cycles", hrs_cyc, NLINES * 96 * DIV);
        chk("multi_period_errors", bad_period, 0);
        chk("multi_max_count", maxcnt, 799);

        // Random resets sprinkled over free running
        repeat (6000) step(($urandom % 300) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
